ctrl_sequencer: RTL and testbench

- Hardwired control unit for the single-bus 32-bit datapath: R0–R15, PC, IR, MAR, MDR, Y, 64-bit Z, HI/LO and the ALU.
- Sequences instruction fetch and execute by driving every register in/out strobe, the ALU select and the memory read/write handshake.
- Decodes the IR output and runs each instruction as T-steps. Stalls on memory ready; stops on halt.

---
 rtl/ctrl_sequencer_pkg.sv | 69 ++++++
 rtl/ctrl_sequencer_if.sv | 29 ++
 rtl/ctrl_sequencer_reg_decode.sv | 23 ++
 rtl/ctrl_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_sequencer_pkg.sv
// Shared constants for the hardwired control unit: opcodes, ALU selects,
// sequencer states and the opcode-to-ALU-select mapping.
package ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_ROL  = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_IN   = 5'd26;
  localparam logic [4:0] OP_NOP  = 5'd27;
  localparam logic [4:0] OP_HALT = 5'd28;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_ROR = 4'd6;
  localparam logic [3:0] ALU_ROL = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_DIV = 4'd9;
  localparam logic [3:0] ALU_NEG = 4'd10;
  localparam logic [3:0] ALU_NOT = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_EX   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  // Immediate forms and address arithmetic reuse the register-form operation
  function automatic logic [3:0] alu_sel(input logic [4:0] op);
    case (op)
      OP_SUB:           alu_sel = ALU_SUB;
      OP_AND, OP_ANDI:  alu_sel = ALU_AND;
      OP_OR, OP_ORI:    alu_sel = ALU_OR;
      OP_SHR:           alu_sel = ALU_SHR;
      OP_SHL:           alu_sel = ALU_SHL;
      OP_ROR:           alu_sel = ALU_ROR;
      OP_ROL:           alu_sel = ALU_ROL;
      OP_MUL:           alu_sel = ALU_MUL;
      OP_DIV:           alu_sel = ALU_DIV;
      OP_NEG:           alu_sel = ALU_NEG;
      OP_NOT:           alu_sel = ALU_NOT;
      default:          alu_sel = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Control bus between the sequencer (master) and the single-bus datapath
// (slave): IR contents, memory handshake and every register strobe.
interface ctrl_sequencer_if #(parameter int NUM_REGS = 16);

  logic [31:0]         ir;
  logic                mem_rdy;
  logic [NUM_REGS-1:0] Rin;
  logic [NUM_REGS-1:0] Rout;
  logic PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, MDRread;
  logic Yin, Zin, ZLowout, ZHighout, HIin, HIout, LOin, LOout, Cout, InPortout;
  logic [3:0]          ALUselect;
  logic                mem_rd;
  logic                mem_wr;

  modport master (
    input  ir, mem_rdy,
    output Rin, Rout, PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, MDRread,
           Yin, Zin, ZLowout, ZHighout, HIin, HIout, LOin, LOout, Cout, InPortout,
           ALUselect, mem_rd, mem_wr
  );

  modport slave (
    output ir, mem_rdy,
    input  Rin, Rout, PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, MDRread,
           Yin, Zin, ZLowout, ZHighout, HIin, HIout, LOin, LOout, Cout, InPortout,
           ALUselect, mem_rd, mem_wr
  );

endinterface

// File: rtl/ctrl_sequencer_reg_decode.sv
// 4-bit register field to one-hot select; all zero when disabled or when the
// field names a register beyond NUM_REGS.
module ctrl_reg_decode #(
  parameter int NUM_REGS = 16
) (
  input  logic [3:0]          field,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  // One-hot expansion of the selected field
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (32'(field) == i)) begin
        onehot[i] = 1'b1;
      end else begin
        onehot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/execute sequencer for the single-bus datapath. Defining
// CTRL_ILLEGAL_TRAP_EN makes undefined opcodes halt and raise illegal_op.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              clr,
  ctrl_sequencer_if.master  bus,
  output logic              run,
  output logic              mem_err
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic              illegal_op
`endif
);

  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] WLIM = WW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t        state_r, state_nx_s;
  logic [2:0]    step_r, step_nx_s;
  logic [WW-1:0] wait_r, wait_nx_s;
  logic          mem_err_r, err_set_s, ill_set_s;
  logic          wait_step_s, last_s, halt_s;
  logic          rin_en_s, rout_en_s;
  logic [3:0]    rout_fld_s;
  logic [4:0]    op_s;
  logic [3:0]    ra_s, rb_s, rc_s;
  logic          unused_s;

  assign op_s     = bus.ir[31:27];
  assign ra_s     = bus.ir[26:23];
  assign rb_s     = bus.ir[22:19];
  assign rc_s     = bus.ir[18:15];
  assign unused_s = ^bus.ir[14:0];

  ctrl_reg_decode #(.NUM_REGS(NUM_REGS)) u_rin_dec (
    .field (ra_s),
    .en    (rin_en_s),
    .onehot(bus.Rin)
  );

  ctrl_reg_decode #(.NUM_REGS(NUM_REGS)) u_rout_dec (
    .field (rout_fld_s),
    .en    (rout_en_s),
    .onehot(bus.Rout)
  );

  // Moore strobe decode and next state/step/wait computation
  always_comb begin
    bus.PCout = 1'b0;   bus.PCin = 1'b0;     bus.IncPC = 1'b0;   bus.IRin = 1'b0;
    bus.MARin = 1'b0;   bus.MDRin = 1'b0;    bus.MDRout = 1'b0;  bus.MDRread = 1'b0;
    bus.Yin = 1'b0;     bus.Zin = 1'b0;      bus.ZLowout = 1'b0; bus.ZHighout = 1'b0;
    bus.HIin = 1'b0;    bus.HIout = 1'b0;    bus.LOin = 1'b0;    bus.LOout = 1'b0;
    bus.Cout = 1'b0;    bus.InPortout = 1'b0;
    bus.mem_rd = 1'b0;  bus.mem_wr = 1'b0;   bus.ALUselect = ALU_ADD;
    rin_en_s = 1'b0;    rout_en_s = 1'b0;    rout_fld_s = rb_s;
    state_nx_s = state_r; step_nx_s = step_r; wait_nx_s = '0;
    wait_step_s = 1'b0; last_s = 1'b0;       halt_s = 1'b0;
    err_set_s = 1'b0;   ill_set_s = 1'b0;

    case (state_r)
      ST_IDLE: state_nx_s = ST_T0;
      ST_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1;
        state_nx_s = ST_T1;
      end
      ST_T1: begin
        bus.mem_rd = 1'b1; bus.MDRread = 1'b1; bus.MDRin = 1'b1;
        wait_step_s = 1'b1;
        state_nx_s = ST_T2;
      end
      ST_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
        state_nx_s = ST_EX;
        step_nx_s = 3'd0;
      end
      ST_EX: begin
        step_nx_s = step_r + 3'd1;
        case (op_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
          OP_ADDI, OP_ANDI, OP_ORI: begin
            case (step_r)
              3'd0: begin rout_en_s = 1'b1; rout_fld_s = rb_s; bus.Yin = 1'b1; end
              3'd1: begin
                if (op_s == OP_ADDI || op_s == OP_ANDI || op_s == OP_ORI) begin
                  bus.Cout = 1'b1;
                end else begin
                  rout_en_s = 1'b1; rout_fld_s = rc_s;
                end
                bus.ALUselect = alu_sel(op_s); bus.Zin = 1'b1;
              end
              3'd2: begin bus.ZLowout = 1'b1; rin_en_s = 1'b1; last_s = 1'b1; end
              default: last_s = 1'b1;
            endcase
          end
          OP_NEG, OP_NOT: begin
            case (step_r)
              3'd0: begin
                rout_en_s = 1'b1; rout_fld_s = rb_s;
                bus.ALUselect = alu_sel(op_s); bus.Zin = 1'b1;
              end
              3'd1: begin bus.ZLowout = 1'b1; rin_en_s = 1'b1; last_s = 1'b1; end
              default: last_s = 1'b1;
            endcase
          end
          OP_MUL, OP_DIV: begin
            case (step_r)
              3'd0: begin rout_en_s = 1'b1; rout_fld_s = ra_s; bus.Yin = 1'b1; end
              3'd1: begin
                rout_en_s = 1'b1; rout_fld_s = rb_s;
                bus.ALUselect = alu_sel(op_s); bus.Zin = 1'b1;
              end
              3'd2: begin bus.ZLowout = 1'b1; bus.LOin = 1'b1; end
              3'd3: begin bus.ZHighout = 1'b1; bus.HIin = 1'b1; last_s = 1'b1; end
              default: last_s = 1'b1;
            endcase
          end
          // ld/ldi/st share the effective-address steps; Y + C forms rb + offset
          OP_LD, OP_LDI, OP_ST: begin
            case (step_r)
              3'd0: begin rout_en_s = 1'b1; rout_fld_s = rb_s; bus.Yin = 1'b1; end
              3'd1: begin bus.Cout = 1'b1; bus.ALUselect = ALU_ADD; bus.Zin = 1'b1; end
              3'd2: begin
                bus.ZLowout = 1'b1;
                if (op_s == OP_LDI) begin
                  rin_en_s = 1'b1; last_s = 1'b1;
                end else begin
                  bus.MARin = 1'b1;
                end
              end
              3'd3: begin
                if (op_s == OP_ST) begin
                  rout_en_s = 1'b1; rout_fld_s = ra_s; bus.MDRin = 1'b1;
                end else begin
                  bus.mem_rd = 1'b1; bus.MDRread = 1'b1; bus.MDRin = 1'b1;
                  wait_step_s = 1'b1;
                end
              end
              3'd4: begin
                if (op_s == OP_ST) begin
                  bus.mem_wr = 1'b1; wait_step_s = 1'b1;
                end else begin
                  bus.MDRout = 1'b1; rin_en_s = 1'b1;
                end
                last_s = 1'b1;
              end
              default: last_s = 1'b1;
            endcase
          end
          OP_MFHI: begin bus.HIout = 1'b1; rin_en_s = 1'b1; last_s = 1'b1; end
          OP_MFLO: begin bus.LOout = 1'b1; rin_en_s = 1'b1; last_s = 1'b1; end
          OP_IN:   begin bus.InPortout = 1'b1; rin_en_s = 1'b1; last_s = 1'b1; end
          OP_NOP:  last_s = 1'b1;
          OP_HALT: halt_s = 1'b1;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            halt_s = 1'b1; ill_set_s = 1'b1;
`else
            last_s = 1'b1;
`endif
          end
        endcase
      end
      ST_HALT: state_nx_s = ST_HALT;
      default: state_nx_s = ST_IDLE;
    endcase

    if (last_s) begin
      state_nx_s = ST_T0; step_nx_s = 3'd0;
    end else if (halt_s) begin
      state_nx_s = ST_HALT; step_nx_s = 3'd0;
    end else begin
      step_nx_s = step_nx_s;
    end

    // A memory step holds its strobes until mem_rdy, or gives up at the limit
    if (wait_step_s && !bus.mem_rdy) begin
      state_nx_s = state_r; step_nx_s = step_r;
      if ((MEM_TIMEOUT > 0) && (wait_r == WLIM)) begin
        state_nx_s = ST_HALT; step_nx_s = 3'd0; err_set_s = 1'b1;
      end else begin
        wait_nx_s = wait_r + WW'(1'b1);
      end
    end else begin
      wait_nx_s = '0;
    end
  end

  // Sequencer state, step and wait counter
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= ST_IDLE;
      step_r  <= 3'd0;
      wait_r  <= '0;
    end else begin
      state_r <= state_nx_s;
      step_r  <= step_nx_s;
      wait_r  <= wait_nx_s;
    end
  end

  // Sticky memory timeout flag
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mem_err_r <= 1'b0;
    end else begin
      mem_err_r <= mem_err_r | err_set_s;
    end
  end

  assign mem_err = mem_err_r;
  assign run     = (state_r != ST_HALT);

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_r;

  // Sticky illegal-opcode flag
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= illegal_r | ill_set_s;
    end
  end

  assign illegal_op = illegal_r;
`else
  logic unused_ill_s;
  assign unused_ill_s = ill_set_s;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed-vector bench for ctrl_sequencer: each cycle the full strobe picture
// {run, ALUselect, Rin, Rout, strobes} is compared to a hand-built expectation.
module tb_ctrl_sequencer;
  import ctrl_pkg::*;

  localparam logic [19:0] S_PCOUT = 20'h80000, S_PCIN = 20'h40000, S_INCPC = 20'h20000;
  localparam logic [19:0] S_IRIN = 20'h10000, S_MARIN = 20'h08000, S_MDRIN = 20'h04000;
  localparam logic [19:0] S_MDROUT = 20'h02000, S_MDRREAD = 20'h01000, S_YIN = 20'h00800;
  localparam logic [19:0] S_ZIN = 20'h00400, S_ZLOW = 20'h00200, S_ZHIGH = 20'h00100;
  localparam logic [19:0] S_HIIN = 20'h00080, S_HIOUT = 20'h00040, S_LOIN = 20'h00020;
  localparam logic [19:0] S_LOOUT = 20'h00010, S_COUT = 20'h00008, S_INPORT = 20'h00004;
  localparam logic [19:0] S_MEMRD = 20'h00002, S_MEMWR = 20'h00001;

  localparam logic [56:0] E_IDLE = {1'b1, 4'd0, 16'd0, 16'd0, 20'd0};
  localparam logic [56:0] E_T0   = {1'b1, 4'd0, 16'd0, 16'd0, S_PCOUT | S_MARIN | S_INCPC};
  localparam logic [56:0] E_T1   = {1'b1, 4'd0, 16'd0, 16'd0, S_MEMRD | S_MDRREAD | S_MDRIN};
  localparam logic [56:0] E_T2   = {1'b1, 4'd0, 16'd0, 16'd0, S_MDROUT | S_IRIN};
  localparam logic [56:0] E_HALT = 57'd0;

  logic clk = 1'b0;
  logic clr;
  logic run, mem_err;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_op;
`endif
  int checks = 0;
  int errors = 0;

  ctrl_sequencer_if #(.NUM_REGS(16)) bus ();

  ctrl_sequencer #(.NUM_REGS(16), .MEM_TIMEOUT(4)) dut (
    .clk    (clk),
    .clr    (clr),
    .bus    (bus),
    .run    (run),
    .mem_err(mem_err)
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  logic [19:0] strb;
  logic [56:0] snap;
  assign strb = {bus.PCout, bus.PCin, bus.IncPC, bus.IRin, bus.MARin, bus.MDRin, bus.MDRout,
                 bus.MDRread, bus.Yin, bus.Zin, bus.ZLowout, bus.ZHighout, bus.HIin, bus.HIout,
                 bus.LOin, bus.LOout, bus.Cout, bus.InPortout, bus.mem_rd, bus.mem_wr};
  assign snap = {run, bus.ALUselect, bus.Rin, bus.Rout, strb};

  function automatic logic [56:0] mk(input logic [3:0] a, input logic [15:0] rin,
                                     input logic [15:0] rout, input logic [19:0] s);
    return {1'b1, a, rin, rout, s};
  endfunction

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; bus.ir = 32'd0; bus.mem_rdy = 1'b0;
    tick();
    checks++;
    if (snap !== E_IDLE) begin errors++; $display("FAIL reset_idle: got %h expected %h", snap, E_IDLE); end
    checks++;
    if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err: got %b expected 0", mem_err); end
`ifdef CTRL_ILLEGAL_TRAP_EN
    checks++;
    if (illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", illegal_op); end
`endif
    tick();
    clr = 1'b0;
    checks++;
    if (snap !== E_IDLE) begin errors++; $display("FAIL reset_release: got %h expected %h", snap, E_IDLE); end
    tick();
  endtask

  task automatic test_fetch_add();
    logic [56:0] e [6];
    e = '{E_T0, E_T1, E_T2, mk(4'd0, 16'h0000, 16'h0002, S_YIN),
          mk(ALU_ADD, 16'h0000, 16'h0004, S_ZIN), mk(4'd0, 16'h0008, 16'h0000, S_ZLOW)};
    bus.ir = enc(OP_ADD, 4'd3, 4'd1, 4'd2);
    bus.mem_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (snap !== e[i]) begin errors++; $display("FAIL add row %0d: got %h expected %h", i, snap, e[i]); end
      tick();
    end
  endtask

  task automatic test_mem_stall();
    logic [56:0] e [11];
    logic        r [11];
    e = '{E_T0, E_T1, E_T2, mk(4'd0, 16'h0, 16'h0002, S_YIN), mk(ALU_ADD, 16'h0, 16'h0, S_COUT | S_ZIN),
          mk(4'd0, 16'h0, 16'h0, S_ZLOW | S_MARIN), E_T1, E_T1, E_T1, E_T1,
          mk(4'd0, 16'h0004, 16'h0, S_MDROUT)};
    r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.ir = enc(OP_LD, 4'd2, 4'd1, 4'd0) | 32'h10;
    for (int i = 0; i < 11; i++) begin
      bus.mem_rdy = r[i];
      checks++;
      if (snap !== e[i]) begin errors++; $display("FAIL ld_stall row %0d: got %h expected %h", i, snap, e[i]); end
      tick();
    end
    bus.mem_rdy = 1'b1;
  endtask

  task automatic test_mul();
    logic [56:0] e [7];
    e = '{E_T0, E_T1, E_T2, mk(4'd0, 16'h0, 16'h0010, S_YIN), mk(ALU_MUL, 16'h0, 16'h0020, S_ZIN),
          mk(4'd0, 16'h0, 16'h0, S_ZLOW | S_LOIN), mk(4'd0, 16'h0, 16'h0, S_ZHIGH | S_HIIN)};
    bus.ir = enc(OP_MUL, 4'd4, 4'd5, 4'd0);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (snap !== e[i]) begin errors++; $display("FAIL mul row %0d: got %h expected %h", i, snap, e[i]); end
      tick();
    end
  endtask

  task automatic test_store();
    logic [56:0] e [9];
    logic        r [9];
    e = '{E_T0, E_T1, E_T2, mk(4'd0, 16'h0, 16'h0004, S_YIN), mk(ALU_ADD, 16'h0, 16'h0, S_COUT | S_ZIN),
          mk(4'd0, 16'h0, 16'h0, S_ZLOW | S_MARIN), mk(4'd0, 16'h0, 16'h0040, S_MDRIN),
          mk(4'd0, 16'h0, 16'h0, S_MEMWR), mk(4'd0, 16'h0, 16'h0, S_MEMWR)};
    r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bus.ir = enc(OP_ST, 4'd6, 4'd2, 4'd0) | 32'h8;
    for (int i = 0; i < 9; i++) begin
      bus.mem_rdy = r[i];
      checks++;
      if (snap !== e[i]) begin errors++; $display("FAIL st row %0d: got %h expected %h", i, snap, e[i]); end
      tick();
    end
    bus.mem_rdy = 1'b1;
  endtask

  task automatic test_short_ops();
    logic [31:0] ins [7];
    int          nex [7];
    logic [56:0] exr [7][3];
    logic [56:0] fe  [3];
    fe = '{E_T0, E_T1, E_T2};
    ins = '{enc(OP_ORI, 4'd2, 4'd3, 4'd0), enc(OP_NEG, 4'd1, 4'd9, 4'd0), enc(OP_IN, 4'd5, 4'd0, 4'd0),
            enc(OP_MFHI, 4'd0, 4'd0, 4'd0), enc(OP_MFLO, 4'd15, 4'd0, 4'd0),
            enc(OP_NOP, 4'd0, 4'd0, 4'd0), enc(OP_LDI, 4'd7, 4'd0, 4'd0)};
    nex = '{3, 2, 1, 1, 1, 1, 3};
    exr[0] = '{mk(4'd0, 16'h0, 16'h0008, S_YIN), mk(ALU_OR, 16'h0, 16'h0, S_COUT | S_ZIN),
               mk(4'd0, 16'h0004, 16'h0, S_ZLOW)};
    exr[1] = '{mk(ALU_NEG, 16'h0, 16'h0200, S_ZIN), mk(4'd0, 16'h0002, 16'h0, S_ZLOW), 57'd0};
    exr[2] = '{mk(4'd0, 16'h0020, 16'h0, S_INPORT), 57'd0, 57'd0};
    exr[3] = '{mk(4'd0, 16'h0001, 16'h0, S_HIOUT), 57'd0, 57'd0};
    exr[4] = '{mk(4'd0, 16'h8000, 16'h0, S_LOOUT), 57'd0, 57'd0};
    exr[5] = '{E_IDLE, 57'd0, 57'd0};
    exr[6] = '{mk(4'd0, 16'h0, 16'h0001, S_YIN), mk(ALU_ADD, 16'h0, 16'h0, S_COUT | S_ZIN),
               mk(4'd0, 16'h0080, 16'h0, S_ZLOW)};
    for (int k = 0; k < 7; k++) begin
      bus.ir = ins[k];
      for (int f = 0; f < 3; f++) begin
        checks++;
        if (snap !== fe[f]) begin errors++; $display("FAIL short%0d fetch %0d: got %h expected %h", k, f, snap, fe[f]); end
        tick();
      end
      for (int j = 0; j < nex[k]; j++) begin
        checks++;
        if (snap !== exr[k][j]) begin errors++; $display("FAIL short%0d ex %0d: got %h expected %h", k, j, snap, exr[k][j]); end
        tick();
      end
    end
    checks++;
    if (snap !== E_T0) begin errors++; $display("FAIL short_end: got %h expected %h", snap, E_T0); end
  endtask

  task automatic test_halt();
    logic [56:0] e [4];
    e = '{E_T0, E_T1, E_T2, E_IDLE};
    bus.ir = 32'hE000_0000;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (snap !== e[i]) begin errors++; $display("FAIL halt row %0d: got %h expected %h", i, snap, e[i]); end
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (snap !== E_HALT) begin errors++; $display("FAIL halted cyc %0d: got %h expected %h", i, snap, E_HALT); end
      tick();
    end
    clr = 1'b1;
    #1;
    checks++;
    if (snap !== E_IDLE) begin errors++; $display("FAIL halt_clr: got %h expected %h", snap, E_IDLE); end
    tick();
    clr = 1'b0;
  endtask

  task automatic test_timeout();
    logic [56:0] e [7];
    clr = 1'b1; bus.mem_rdy = 1'b0;
    tick();
    clr = 1'b0;
    checks++;
    if (snap !== E_IDLE) begin errors++; $display("FAIL to_idle: got %h expected %h", snap, E_IDLE); end
    tick();
    checks++;
    if (snap !== E_T0) begin errors++; $display("FAIL to_t0: got %h expected %h", snap, E_T0); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({snap, mem_err} !== {E_T1, 1'b0}) begin
        errors++; $display("FAIL to_wait %0d: got %h err=%b expected %h err=0", i, snap, mem_err, E_T1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({snap, mem_err} !== {E_HALT, 1'b1}) begin
        errors++; $display("FAIL to_halt %0d: got %h err=%b expected %h err=1", i, snap, mem_err, E_HALT);
      end
    end
    clr = 1'b1;
    #1;
    checks++;
    if ({snap, mem_err} !== {E_IDLE, 1'b0}) begin
      errors++; $display("FAIL to_clr: got %h err=%b expected %h err=0", snap, mem_err, E_IDLE);
    end
    tick();
    clr = 1'b0;
    bus.mem_rdy = 1'b1;
    tick();
    // st interrupted by clr while its write is still waiting
    e = '{E_T0, E_T1, E_T2, mk(4'd0, 16'h0, 16'h0004, S_YIN), mk(ALU_ADD, 16'h0, 16'h0, S_COUT | S_ZIN),
          mk(4'd0, 16'h0, 16'h0, S_ZLOW | S_MARIN), mk(4'd0, 16'h0, 16'h0040, S_MDRIN)};
    bus.ir = enc(OP_ST, 4'd6, 4'd2, 4'd0);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (snap !== e[i]) begin errors++; $display("FAIL st_clr row %0d: got %h expected %h", i, snap, e[i]); end
      tick();
    end
    bus.mem_rdy = 1'b0;
    checks++;
    if (snap !== mk(4'd0, 16'h0, 16'h0, S_MEMWR)) begin
      errors++; $display("FAIL st_clr wr: got %h expected %h", snap, mk(4'd0, 16'h0, 16'h0, S_MEMWR));
    end
    clr = 1'b1;
    #1;
    checks++;
    if (snap !== E_IDLE) begin errors++; $display("FAIL st_clr idle: got %h expected %h", snap, E_IDLE); end
    tick();
    clr = 1'b0;
    bus.mem_rdy = 1'b1;
    tick();
  endtask

  task automatic test_illegal();
    logic [56:0] e [4];
    e = '{E_T0, E_T1, E_T2, E_IDLE};
    bus.ir = enc(5'd31, 4'd1, 4'd2, 4'd3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (snap !== e[i]) begin errors++; $display("FAIL illegal row %0d: got %h expected %h", i, snap, e[i]); end
      tick();
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
    checks++;
    if ({snap, illegal_op} !== {E_HALT, 1'b1}) begin
      errors++; $display("FAIL illegal_trap: got %h ill=%b expected %h ill=1", snap, illegal_op, E_HALT);
    end
`else
    checks++;
    if (snap !== E_T0) begin errors++; $display("FAIL illegal_nop: got %h expected %h", snap, E_T0); end
`endif
  endtask

  initial begin
    test_reset();
    test_fetch_add();
    test_mem_stall();
    test_mul();
    test_store();
    test_short_ops();
    test_halt();
    test_timeout();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
